wrapper_clint_slave: RTL and testbench

WRAPPER_CLINT_SLAVE -- requirements
Module: wrapper_clint_slave

---
 rtl/wrapper_clint_pkg.sv | 43 ++++
 rtl/wrapper_clint_rtc_sync.sv | 32 +++
 rtl/wrapper_clint_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_wrapper_clint_slave.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrapper_clint_pkg.sv
// Shared definitions for the CLINT AXI4-Lite responder.
// Holds the register word offsets (address bits [15:3]), AXI response
// codes, the read/write FSM state types and the byte-strobe merge helper.
package wrapper_clint_pkg;

    // Word offsets (byte offset >> 3) of the mapped registers
    localparam logic [12:0] MSIP_WORD     = 13'h0000;  // byte offset 0x0000
    localparam logic [12:0] MTIMECMP_WORD = 13'h0800;  // byte offset 0x4000
    localparam logic [12:0] MTIME_WORD    = 13'h17FF;  // byte offset 0xBFF8

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_e;

    // Byte-wise merge of new_v into old_v under strobe control
    function automatic logic [63:0] apply_strb(
        input logic [63:0] old_v,
        input logic [63:0] new_v,
        input logic [7:0]  strb
    );
        logic [63:0] res;
        res = 64'h0;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wrapper_clint_rtc_sync.sv
// Real-time tick synchronizer for the CLINT.
// Brings the asynchronous rtc_i into the clk_i domain through two flops and
// produces a one-cycle tick_o for every synchronized rising edge.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   rtc_i   - asynchronous real-time tick input
//   tick_o  - single-cycle pulse per synchronized rtc_i rising edge
module wrapper_clint_rtc_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rtc_i,
    output logic tick_o
);

    logic [1:0] sync_r;
    logic       last_r;

    // Two-flop synchronizer followed by a history flop for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_r <= 2'b00;
            last_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], rtc_i};
            last_r <= sync_r[1];
        end
    end

    assign tick_o = sync_r[1] & ~last_r;

endmodule

// File: rtl/wrapper_clint_slave.sv
// CLINT (core-local interruptor) AXI4-Lite responder.
// Provides msip, mtimecmp and mtime in the 0x0200_0000 window, decoding
// only address bits [15:3]. mtime advances on each synchronized rtc_i
// rising edge; timer_irq_o and ipi_o are registered interrupt outputs.
// Ports:
//   clk_i, rst_ni                 - clock, asynchronous active-low reset
//   aw_* / w_* / b_*              - AXI4-Lite write address/data/response
//   ar_* / r_*                    - AXI4-Lite read address/data
//   rtc_i                         - asynchronous real-time tick
//   timer_irq_o                   - machine timer interrupt (mtime >= mtimecmp)
//   ipi_o                         - machine software interrupt (msip bit 0)
module wrapper_clint_slave
    import wrapper_clint_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    output logic [1:0]             b_resp_o,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    input  logic                   rtc_i,
    output logic                   timer_irq_o,
    output logic                   ipi_o
);

    wr_state_e   wr_state_r, wr_next_s;
    rd_state_e   rd_state_r, rd_next_s;
    logic        alive_r;
    logic        tick_s;
    logic        wr_hs_s, ar_hs_s;
    logic [12:0] aw_word_s, ar_word_s;
    logic        wr_msip_s, wr_cmp_s, wr_time_s, wr_mapped_s;
    logic [63:0] rd_data_s;
    logic [1:0]  rd_resp_s;
    logic        msip_r;
    logic [63:0] mtimecmp_r, mtime_r;
    logic [1:0]  b_resp_r, r_resp_r;
    logic [63:0] r_data_r;
    logic        irq_r, ipi_r;
    logic        unused_addr_s;

    assign aw_word_s     = aw_addr_i[15:3];
    assign ar_word_s     = ar_addr_i[15:3];
    assign unused_addr_s = ^{aw_addr_i[AddrWidth-1:16], aw_addr_i[2:0],
                             ar_addr_i[AddrWidth-1:16], ar_addr_i[2:0]};

    wrapper_clint_rtc_sync u_rtc_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rtc_i  (rtc_i),
        .tick_o (tick_s)
    );

    // Holds the ready outputs low until the first clock edge after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alive_r <= 1'b0;
        end else begin
            alive_r <= 1'b1;
        end
    end

    // Address and data are accepted together, so both readies share one term
    assign wr_hs_s    = (wr_state_r == WR_IDLE) && alive_r && aw_valid_i && w_valid_i;
    assign aw_ready_o = wr_hs_s;
    assign w_ready_o  = wr_hs_s;
    assign ar_ready_o = (rd_state_r == RD_IDLE) && alive_r;
    assign ar_hs_s    = ar_ready_o && ar_valid_i;

    // Write address decode
    always_comb begin
        wr_msip_s = 1'b0;
        wr_cmp_s  = 1'b0;
        wr_time_s = 1'b0;
        case (aw_word_s)
            MSIP_WORD:     wr_msip_s = 1'b1;
            MTIMECMP_WORD: wr_cmp_s  = 1'b1;
            MTIME_WORD:    wr_time_s = 1'b1;
            default: begin
                wr_msip_s = 1'b0;
            end
        endcase
    end

    assign wr_mapped_s = wr_msip_s | wr_cmp_s | wr_time_s;

    // Read data mux; unmapped offsets read zero with SLVERR
    always_comb begin
        rd_data_s = 64'h0;
        rd_resp_s = RESP_OKAY;
        case (ar_word_s)
            MSIP_WORD:     rd_data_s = {63'h0, msip_r};
            MTIMECMP_WORD: rd_data_s = mtimecmp_r;
            MTIME_WORD:    rd_data_s = mtime_r;
            default:       rd_resp_s = RESP_SLVERR;
        endcase
    end

    // Write FSM next state
    always_comb begin
        wr_next_s = wr_state_r;
        case (wr_state_r)
            WR_IDLE: begin
                if (wr_hs_s) begin
                    wr_next_s = WR_RESP;
                end else begin
                    wr_next_s = WR_IDLE;
                end
            end
            WR_RESP: begin
                if (b_ready_i) begin
                    wr_next_s = WR_IDLE;
                end else begin
                    wr_next_s = WR_RESP;
                end
            end
            default: wr_next_s = WR_IDLE;
        endcase
    end

    // Read FSM next state
    always_comb begin
        rd_next_s = rd_state_r;
        case (rd_state_r)
            RD_IDLE: begin
                if (ar_hs_s) begin
                    rd_next_s = RD_DATA;
                end else begin
                    rd_next_s = RD_IDLE;
                end
            end
            RD_DATA: begin
                if (r_ready_i) begin
                    rd_next_s = RD_IDLE;
                end else begin
                    rd_next_s = RD_DATA;
                end
            end
            default: rd_next_s = RD_IDLE;
        endcase
    end

    // FSM state registers and latched response payloads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_r <= WR_IDLE;
            rd_state_r <= RD_IDLE;
            b_resp_r   <= RESP_OKAY;
            r_resp_r   <= RESP_OKAY;
            r_data_r   <= 64'h0;
        end else begin
            wr_state_r <= wr_next_s;
            rd_state_r <= rd_next_s;
            if (wr_hs_s) begin
                b_resp_r <= wr_mapped_s ? RESP_OKAY : RESP_SLVERR;
            end
            if (ar_hs_s) begin
                r_data_r <= rd_data_s;
                r_resp_r <= rd_resp_s;
            end
        end
    end

    // CLINT registers; a bus write to mtime overrides a coincident tick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msip_r     <= 1'b0;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime_r    <= 64'h0;
        end else begin
            if (wr_hs_s && wr_msip_s && w_strb_i[0]) begin
                msip_r <= w_data_i[0];
            end
            if (wr_hs_s && wr_cmp_s) begin
                mtimecmp_r <= apply_strb(mtimecmp_r, w_data_i, w_strb_i);
            end
            if (wr_hs_s && wr_time_s) begin
                mtime_r <= apply_strb(mtime_r, w_data_i, w_strb_i);
            end else if (tick_s) begin
                mtime_r <= mtime_r + 64'd1;
            end
        end
    end

    // Registered interrupt outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_r <= 1'b0;
            ipi_r <= 1'b0;
        end else begin
            irq_r <= (mtime_r >= mtimecmp_r);
            ipi_r <= msip_r;
        end
    end

    assign b_valid_o   = (wr_state_r == WR_RESP);
    assign b_resp_o    = b_resp_r;
    assign r_valid_o   = (rd_state_r == RD_DATA);
    assign r_data_o    = r_data_r;
    assign r_resp_o    = r_resp_r;
    assign timer_irq_o = irq_r;
    assign ipi_o       = ipi_r;

endmodule

// File: tb/tb_wrapper_clint_slave.sv
// Self-checking bench for wrapper_clint_slave: a transaction-level model of
// the CLINT registers and channel occupancy is stepped every clock edge and
// compared with the DUT outputs on every falling edge, alongside literal
// expectations for the directed scenarios and a randomized traffic phase.
module tb_wrapper_clint_slave;

    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] A_MSIP = 32'h0200_0000;
    localparam logic [31:0] A_CMP  = 32'h0200_4000;
    localparam logic [31:0] A_TIME = 32'h0200_BFF8;
    localparam logic [31:0] A_BAD  = 32'h0200_8000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] aw_addr_i = 32'h0;
    logic        aw_valid_i = 1'b0;
    logic        aw_ready_o;
    logic [63:0] w_data_i = 64'h0;
    logic [7:0]  w_strb_i = 8'h0;
    logic        w_valid_i = 1'b0;
    logic        w_ready_o;
    logic [1:0]  b_resp_o;
    logic        b_valid_o;
    logic        b_ready_i = 1'b0;
    logic [31:0] ar_addr_i = 32'h0;
    logic        ar_valid_i = 1'b0;
    logic        ar_ready_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_valid_o;
    logic        r_ready_i = 1'b0;
    logic        rtc_i = 1'b0;
    logic        timer_irq_o;
    logic        ipi_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit rtc_rand = 1'b0;

    always #5 clk_i = ~clk_i;

    wrapper_clint_slave #(.AddrWidth(32), .DataWidth(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .rtc_i(rtc_i), .timer_irq_o(timer_irq_o), .ipi_o(ipi_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mtime = 64'h0, m_cmp = ONES, m_rdata = 64'h0;
    logic        m_msip = 1'b0, m_ipi = 1'b0, m_irq = 1'b0, m_alive = 1'b0;
    logic        m_wbusy = 1'b0, m_rbusy = 1'b0, m_rtc_prev = 1'b0;
    logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
    int unsigned m_cyc = 0;
    int unsigned m_due[$];

    // 0 = msip, 1 = mtimecmp, 2 = mtime, 3 = unmapped
    function automatic int region(input logic [31:0] a);
        logic [15:0] off;
        off = a[15:0] & 16'hFFF8;
        if (off == 16'h0000) return 0;
        else if (off == 16'h4000) return 1;
        else if (off == 16'hBFF8) return 2;
        else return 3;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
        logic [63:0] mask;
        mask = 64'h0;
        for (int b = 0; b < 8; b++) if (s[b]) mask = mask | (64'hFF << (8 * b));
        return (o & ~mask) | (n & mask);
    endfunction

    task automatic model_step();
        logic wr_hs, rd_hs, tick, nirq, nipi, nmsip;
        logic [63:0] nt, nc;
        int rg;
        if (!rst_ni) begin
            m_mtime = 64'h0; m_cmp = ONES; m_msip = 1'b0; m_ipi = 1'b0; m_irq = 1'b0;
            m_alive = 1'b0; m_wbusy = 1'b0; m_rbusy = 1'b0; m_rtc_prev = 1'b0;
            m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 64'h0;
            m_due.delete();
            m_cyc++;
            return;
        end
        // a rise of rtc seen at an edge advances mtime two edges later
        tick = 1'b0;
        while (m_due.size() > 0 && m_due[0] == m_cyc) begin
            tick = 1'b1;
            void'(m_due.pop_front());
        end
        if (rtc_i && !m_rtc_prev) m_due.push_back(m_cyc + 2);
        m_rtc_prev = rtc_i;

        wr_hs = m_alive && !m_wbusy && aw_valid_i && w_valid_i;
        rd_hs = m_alive && !m_rbusy && ar_valid_i;
        nirq  = (m_mtime >= m_cmp);
        nipi  = m_msip;
        nmsip = m_msip; nc = m_cmp; nt = m_mtime;

        if (rd_hs) begin
            rg = region(ar_addr_i);
            case (rg)
                0: m_rdata = {63'h0, m_msip};
                1: m_rdata = m_cmp;
                2: m_rdata = m_mtime;
                default: m_rdata = 64'h0;
            endcase
            m_rresp = (rg == 3) ? 2'b10 : 2'b00;
        end
        if (m_rbusy && r_ready_i) m_rbusy = 1'b0;
        else if (rd_hs) m_rbusy = 1'b1;

        if (tick) nt = m_mtime + 64'd1;
        if (wr_hs) begin
            rg = region(aw_addr_i);
            case (rg)
                0: if (w_strb_i[0]) nmsip = w_data_i[0];
                1: nc = merge(m_cmp, w_data_i, w_strb_i);
                2: nt = merge(m_mtime, w_data_i, w_strb_i);
                default: ;
            endcase
            m_bresp = (rg == 3) ? 2'b10 : 2'b00;
        end
        if (m_wbusy && b_ready_i) m_wbusy = 1'b0;
        else if (wr_hs) m_wbusy = 1'b1;

        m_msip = nmsip; m_cmp = nc; m_mtime = nt;
        m_irq = nirq; m_ipi = nipi; m_alive = 1'b1;
        m_cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic hs_exp;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                chk("reset_flags", {57'h0, aw_ready_o, w_ready_o, ar_ready_o, b_valid_o,
                                    r_valid_o, ipi_o, timer_irq_o}, 64'h0);
                chk("reset_rdata", r_data_o, 64'h0);
                chk("reset_resp", {60'h0, b_resp_o, r_resp_o}, 64'h0);
            end else begin
                hs_exp = m_alive && !m_wbusy && aw_valid_i && w_valid_i;
                chk("flags", {57'h0, aw_ready_o, w_ready_o, ar_ready_o, b_valid_o,
                              r_valid_o, ipi_o, timer_irq_o},
                             {57'h0, hs_exp, hs_exp, m_alive && !m_rbusy, m_wbusy,
                              m_rbusy, m_ipi, m_irq});
                if (m_wbusy) chk("b_resp", {62'h0, b_resp_o}, {62'h0, m_bresp});
                if (m_rbusy) begin
                    chk("r_data", r_data_o, m_rdata);
                    chk("r_resp", {62'h0, r_resp_o}, {62'h0, m_rresp});
                end
            end
        end
    end

    // random rtc activity, enabled only during the random phase
    initial begin
        forever begin
            @(posedge clk_i); #1;
            if (rtc_rand && $urandom_range(0, 3) == 0) rtc_i = ~rtc_i;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- drivers (called at posedge + 1) ----------------
    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                      input int hold, input bit poke, output logic [1:0] resp);
        bit hs, got;
        resp = 2'b11;
        aw_addr_i = a; w_data_i = d; w_strb_i = s; aw_valid_i = 1'b1; w_valid_i = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk_i); hs = aw_ready_o;
            step();
        end
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        if (!hs) begin chk("aw_handshake", 64'h0, 64'h1); return; end
        for (int i = 0; i < hold; i++) begin
            if (poke) begin w_data_i = ~d; aw_valid_i = 1'b1; w_valid_i = 1'b1; end
            step();
        end
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        b_ready_i = 1'b1; got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_i);
            if (b_valid_o) begin got = 1'b1; resp = b_resp_o; end
            step();
        end
        b_ready_i = 1'b0;
        if (!got) chk("b_handshake", 64'h0, 64'h1);
    endtask

    task automatic rd(input logic [31:0] a, input int hold, input bit poke,
                      output logic [63:0] data, output logic [1:0] resp);
        bit hs, got;
        data = 64'h0; resp = 2'b11;
        ar_addr_i = a; ar_valid_i = 1'b1; hs = 1'b0;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge clk_i); hs = ar_ready_o;
            step();
        end
        ar_valid_i = 1'b0;
        if (!hs) begin chk("ar_handshake", 64'h0, 64'h1); return; end
        for (int i = 0; i < hold; i++) begin
            if (poke) ar_valid_i = 1'b1;
            step();
        end
        ar_valid_i = 1'b0;
        r_ready_i = 1'b1; got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_i);
            if (r_valid_o) begin got = 1'b1; data = r_data_o; resp = r_resp_o; end
            step();
        end
        r_ready_i = 1'b0;
        if (!got) chk("r_handshake", 64'h0, 64'h1);
    endtask

    task automatic rtc_pulse();
        rtc_i = 1'b1; step(); step();
        rtc_i = 1'b0; step(); step();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0: a = A_MSIP;
            1: a = A_CMP;
            2, 3: a = A_TIME;
            4: a = A_BAD;
            default: a = 32'h0200_0000 | $urandom_range(0, 65535);
        endcase
        return a | $urandom_range(0, 7) | ({$urandom} & 32'hFFF0_0000);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  bresp, rresp, bresp2;
        logic [63:0] rdata;
        logic [31:0] wa, ra;
        logic [63:0] wd;
        logic [7:0]  ws;
        int          k;
        bit          seen;

        repeat (3) step();
        rst_ni = 1'b1;
        step();

        // reset values
        rd(A_CMP, 0, 1'b0, rdata, rresp);
        chk("reset_mtimecmp", rdata, ONES);
        rd(A_TIME, 0, 1'b0, rdata, rresp);
        chk("reset_mtime", rdata, 64'h0);

        // timer compare after 16 rtc ticks
        wr(A_CMP, 64'h10, 8'hFF, 0, 1'b0, bresp);
        chk("cmp_write_resp", {62'h0, bresp}, 64'h0);
        for (int p = 0; p < 15; p++) rtc_pulse();
        chk("irq_before_16", {63'h0, timer_irq_o}, 64'h0);
        rtc_i = 1'b1; k = 0; seen = 1'b0;
        while (!seen && k < 8) begin
            @(negedge clk_i);
            if (timer_irq_o) seen = 1'b1;
            else begin step(); k++; if (k == 2) rtc_i = 1'b0; end
        end
        step(); rtc_i = 1'b0; step(); step();
        chk("irq_rises", {63'h0, seen}, 64'h1);
        chk("irq_latency_ok", {63'h0, k <= 5}, 64'h1);
        rd(A_TIME, 0, 1'b0, rdata, rresp);
        chk("mtime_after_16", rdata, 64'h10);
        chk("mtime_read_resp", {62'h0, rresp}, 64'h0);

        // software interrupt
        wr(A_MSIP, ONES, 8'hFF, 0, 1'b0, bresp);
        chk("msip_write_resp", {62'h0, bresp}, 64'h0);
        chk("ipi_set", {63'h0, ipi_o}, 64'h1);
        rd(A_MSIP, 0, 1'b0, rdata, rresp);
        chk("msip_readback", rdata, 64'h1);
        wr(A_MSIP, 64'h0, 8'hFF, 0, 1'b0, bresp);
        chk("ipi_clear", {63'h0, ipi_o}, 64'h0);

        // unmapped offset
        wr(A_BAD, 64'hDEAD, 8'hFF, 0, 1'b0, bresp);
        chk("bad_write_resp", {62'h0, bresp}, 64'h2);
        rd(A_BAD, 0, 1'b0, rdata, rresp);
        chk("bad_read_data", rdata, 64'h0);
        chk("bad_read_resp", {62'h0, rresp}, 64'h2);

        // mtime wrap, then write coincident with a tick
        wr(A_TIME, ONES, 8'hFF, 0, 1'b0, bresp);
        rtc_pulse(); step();
        rd(A_TIME, 0, 1'b0, rdata, rresp);
        chk("mtime_wrap", rdata, 64'h0);
        rtc_i = 1'b1; step(); step();
        wr(A_TIME, 64'h1234, 8'hFF, 0, 1'b0, bresp);
        rtc_i = 1'b0; step(); step(); step();
        rd(A_TIME, 0, 1'b0, rdata, rresp);
        chk("mtime_write_priority", rdata, 64'h1234);

        // byte strobes and the empty strobe
        wr(A_CMP, 64'h1122_3344_5566_7788, 8'h0F, 0, 1'b0, bresp);
        rd(A_CMP, 0, 1'b0, rdata, rresp);
        chk("cmp_strobe_low", rdata, 64'h0000_0000_5566_7788);
        wr(A_CMP, ONES, 8'h00, 0, 1'b0, bresp);
        chk("zero_strobe_resp", {62'h0, bresp}, 64'h0);
        rd(A_CMP, 0, 1'b0, rdata, rresp);
        chk("zero_strobe_noop", rdata, 64'h0000_0000_5566_7788);

        // aw without w is not accepted
        aw_addr_i = A_CMP; aw_valid_i = 1'b1; w_valid_i = 1'b0;
        repeat (4) begin @(negedge clk_i); chk("aw_alone_ready", {63'h0, aw_ready_o}, 64'h0); step(); end
        aw_valid_i = 1'b0;

        // back-pressure on both response channels with competing requests
        fork
            wr(A_CMP, 64'hABCD, 8'hFF, 10, 1'b1, bresp);
            rd(A_TIME, 10, 1'b1, rdata, rresp);
        join
        rd(A_CMP, 0, 1'b0, rdata, rresp);
        chk("no_accept_while_busy", rdata, 64'hABCD);

        // randomized traffic with random rtc activity
        rtc_rand = 1'b1;
        for (int it = 0; it < 200; it++) begin
            wa = rand_addr(); ra = rand_addr();
            wd = {$urandom, $urandom};
            ws = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: wr(wa, wd, ws, $urandom_range(0, 3), 1'($urandom_range(0, 1)), bresp);
                1: rd(ra, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rdata, rresp);
                default: fork
                    wr(wa, wd, ws, $urandom_range(0, 3), 1'b0, bresp2);
                    rd(ra, $urandom_range(0, 3), 1'b0, rdata, rresp);
                join
            endcase
            if ($urandom_range(0, 3) == 0) step();
        end
        rtc_rand = 1'b0; rtc_i = 1'b0;
        repeat (4) step();

        // reset while a write response is pending
        aw_addr_i = A_CMP; w_data_i = 64'h5; w_strb_i = 8'hFF;
        aw_valid_i = 1'b1; w_valid_i = 1'b1;
        step();
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        @(negedge clk_i);
        chk("b_valid_before_reset", {63'h0, b_valid_o}, 64'h1);
        #2 rst_ni = 1'b0;
        #1 chk("b_valid_reset_now", {63'h0, b_valid_o}, 64'h0);
        step(); step();
        rst_ni = 1'b1;
        repeat (3) begin
            @(negedge clk_i); chk("no_b_after_reset", {63'h0, b_valid_o}, 64'h0); step();
        end
        rd(A_CMP, 0, 1'b0, rdata, rresp);
        chk("mtimecmp_after_reset", rdata, ONES);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
